// File: rtl/core_id_pipe_pkg.sv
// Shared RV32I decode constants for the ID stage: opcodes, op-class codes,
// func3/func7 values and write-enable encodings.
package core_id_pipe_pkg;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [3:0] OPC_ILLEGAL = 4'd0;
    localparam logic [3:0] OPC_LUI     = 4'd1;
    localparam logic [3:0] OPC_AUIPC   = 4'd2;
    localparam logic [3:0] OPC_JAL     = 4'd3;
    localparam logic [3:0] OPC_JALR    = 4'd4;
    localparam logic [3:0] OPC_BRANCH  = 4'd5;
    localparam logic [3:0] OPC_LOAD    = 4'd6;
    localparam logic [3:0] OPC_STORE   = 4'd7;
    localparam logic [3:0] OPC_OP_IMM  = 4'd8;
    localparam logic [3:0] OPC_OP      = 4'd9;
    localparam logic [3:0] OPC_FENCE   = 4'd10;
    localparam logic [3:0] OPC_SYSTEM  = 4'd11;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [4:0] ZeroReg      = 5'd0;
    localparam logic       WriteEnable  = 1'b1;
    localparam logic       WriteDisable = 1'b0;

    // Shift-immediates carry a 5-bit shamt instead of a 12-bit immediate.
    function automatic logic is_shift_imm(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SRX);
    endfunction

endpackage

// File: rtl/core_id_decode.sv
// Purely combinational RV32I decode: op class, immediate, register
// addresses, write-back enable and illegal-instruction flag.
module core_id_decode
    import core_id_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int OPC_W  = 4
) (
    input  logic [31:0]       inst_i,
    output logic [OPC_W-1:0]  opclass_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [REG_AW-1:0] rs1_o,
    output logic [REG_AW-1:0] rs2_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              we_o,
    output logic              illegal_o,
    output logic [2:0]        func3_o,
    output logic [6:0]        func7_o
);

    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [REG_AW-1:0] rd_f;
    logic              sgn;
    logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic [3:0]        opc;
    logic [XLEN-1:0]   imm;
    logic              use_rs1, use_rs2, writes_rd, bad;

    assign opcode = inst_i[6:0];
    assign f3     = inst_i[14:12];
    assign f7     = inst_i[31:25];
    assign rd_f   = REG_AW'(inst_i[11:7]);
    assign sgn    = inst_i[31];

    assign imm_i  = {{(XLEN-11){sgn}}, inst_i[30:20]};
    assign imm_s  = {{(XLEN-11){sgn}}, inst_i[30:25], inst_i[11:7]};
    assign imm_b  = {{(XLEN-12){sgn}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u  = {{(XLEN-31){sgn}}, inst_i[30:12], 12'b0};
    assign imm_j  = {{(XLEN-20){sgn}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign imm_sh = {{(XLEN-5){1'b0}}, inst_i[24:20]};

    always_comb begin
        opc       = OPC_ILLEGAL;
        imm       = '0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = WriteDisable;
        bad       = 1'b0;
        if (inst_i[1:0] != 2'b11) begin
            bad = 1'b1;
        end else begin
            case (opcode)
                OpLui:    begin opc = OPC_LUI;   imm = imm_u; writes_rd = WriteEnable; end
                OpAuipc:  begin opc = OPC_AUIPC; imm = imm_u; writes_rd = WriteEnable; end
                OpJal:    begin opc = OPC_JAL;   imm = imm_j; writes_rd = WriteEnable; end
                OpJalr:   begin opc = OPC_JALR;  imm = imm_i; use_rs1 = 1'b1; writes_rd = WriteEnable; end
                OpBranch: begin opc = OPC_BRANCH; imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; end
                OpLoad:   begin opc = OPC_LOAD;  imm = imm_i; use_rs1 = 1'b1; writes_rd = WriteEnable; end
                OpStore:  begin opc = OPC_STORE; imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1; end
                OpOpImm: begin
                    opc       = OPC_OP_IMM;
                    imm       = is_shift_imm(f3) ? imm_sh : imm_i;
                    use_rs1   = 1'b1;
                    writes_rd = WriteEnable;
                end
                OpOp: begin
                    // Only the base and alternate (SUB/SRA) func7 encodings exist in RV32I.
                    if (!(f7 == F7_BASE || f7 == F7_ALT) ||
                        (f7 == F7_ALT && !(f3 == F3_ADD || f3 == F3_SRX))) begin
                        bad = 1'b1;
                    end else begin
                        opc       = OPC_OP;
                        use_rs1   = 1'b1;
                        use_rs2   = 1'b1;
                        writes_rd = WriteEnable;
                    end
                end
                OpFence:  begin opc = OPC_FENCE;  imm = imm_i; end
                OpSystem: begin opc = OPC_SYSTEM; imm = imm_i; use_rs1 = 1'b1; end
                default:  bad = 1'b1;
            endcase
        end
    end

    assign opclass_o = OPC_W'(opc);
    assign imm_o     = imm;
    assign illegal_o = bad;
    assign we_o      = writes_rd && (rd_f != REG_AW'(ZeroReg));
    assign rd_o      = we_o ? rd_f : '0;
    assign rs1_o     = use_rs1 ? REG_AW'(inst_i[19:15]) : '0;
    assign rs2_o     = use_rs2 ? REG_AW'(inst_i[24:20]) : '0;
    assign func3_o   = f3;
    assign func7_o   = f7;

endmodule

// File: rtl/core_id_pipe.sv
// Registered RV32I decode stage with a 2-entry skid buffer, flush and
// valid/ready handshake to EX. Optional load-use stall: CORE_ID_HAZARD_EN.
module core_id_pipe
    import core_id_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int OPC_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst_in,
    input  logic [XLEN-1:0]   inst_addr_in,
    output logic [REG_AW-1:0] read_reg1_addr_out,
    output logic [REG_AW-1:0] read_reg2_addr_out,
    input  logic [XLEN-1:0]   read_reg1_data_in,
    input  logic [XLEN-1:0]   read_reg2_data_in,
`ifdef CORE_ID_HAZARD_EN
    input  logic              ex_load_valid_in,
    input  logic [REG_AW-1:0] ex_rd_in,
    output logic              hazard_stall_out,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       inst_out,
    output logic [XLEN-1:0]   inst_addr_out,
    output logic [OPC_W-1:0]  opclass_out,
    output logic [2:0]        func3_out,
    output logic [6:0]        func7_out,
    output logic [XLEN-1:0]   imm_out,
    output logic              reg_we_out,
    output logic [REG_AW-1:0] reg_write_addr_out,
    output logic [XLEN-1:0]   reg1_data_out,
    output logic [XLEN-1:0]   reg2_data_out,
    output logic              illegal_out
);

    typedef struct packed {
        logic [31:0]       inst;
        logic [XLEN-1:0]   addr;
        logic [OPC_W-1:0]  opclass;
        logic [2:0]        func3;
        logic [6:0]        func7;
        logic [XLEN-1:0]   imm;
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   rdata1;
        logic [XLEN-1:0]   rdata2;
        logic              illegal;
`ifdef CORE_ID_HAZARD_EN
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
`endif
    } entry_t;

    entry_t      incoming, main_d, main_q, skid_d, skid_q;
    logic        main_vld_d, main_vld_q, skid_vld_d, skid_vld_q;
    logic        in_ready_d, in_ready_q;
    logic        accept, drain, hazard;
    logic [REG_AW-1:0] rs1, rs2;

    core_id_decode #(.XLEN(XLEN), .REG_AW(REG_AW), .OPC_W(OPC_W)) u_decode (
        .inst_i    (inst_in),
        .opclass_o (incoming.opclass),
        .imm_o     (incoming.imm),
        .rs1_o     (rs1),
        .rs2_o     (rs2),
        .rd_o      (incoming.rd),
        .we_o      (incoming.we),
        .illegal_o (incoming.illegal),
        .func3_o   (incoming.func3),
        .func7_o   (incoming.func7)
    );

    assign incoming.inst = inst_in;
    assign incoming.addr = inst_addr_in;
    // Unused operand slots decode to x0, so this also zeroes data the format ignores.
    assign incoming.rdata1 = (rs1 == '0) ? '0 : read_reg1_data_in;
    assign incoming.rdata2 = (rs2 == '0) ? '0 : read_reg2_data_in;
`ifdef CORE_ID_HAZARD_EN
    assign incoming.rs1 = rs1;
    assign incoming.rs2 = rs2;
`endif

    assign read_reg1_addr_out = rs1;
    assign read_reg2_addr_out = rs2;

`ifdef CORE_ID_HAZARD_EN
    assign hazard = main_vld_q && ex_load_valid_in && (ex_rd_in != '0) &&
                    ((main_q.rs1 == ex_rd_in) || (main_q.rs2 == ex_rd_in));
    assign hazard_stall_out = hazard;
`else
    assign hazard = 1'b0;
`endif

    assign out_valid = main_vld_q && !hazard;
    assign in_ready  = in_ready_q;
    assign accept    = in_valid && in_ready_q && !flush_in;
    assign drain     = out_valid && out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush_in) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (drain) begin
            // in_ready is low whenever skid holds data, so skid refill and accept never collide.
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d = incoming;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (main_vld_q) begin
                skid_d     = incoming;
                skid_vld_d = 1'b1;
            end else begin
                main_d     = incoming;
                main_vld_d = 1'b1;
            end
        end
        in_ready_d = !skid_vld_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    // An empty stage presents an all-zero bundle.
    assign inst_out           = main_vld_q ? main_q.inst    : '0;
    assign inst_addr_out      = main_vld_q ? main_q.addr    : '0;
    assign opclass_out        = main_vld_q ? main_q.opclass : '0;
    assign func3_out          = main_vld_q ? main_q.func3   : '0;
    assign func7_out          = main_vld_q ? main_q.func7   : '0;
    assign imm_out            = main_vld_q ? main_q.imm     : '0;
    assign reg_we_out         = main_vld_q ? main_q.we      : 1'b0;
    assign reg_write_addr_out = main_vld_q ? main_q.rd      : '0;
    assign reg1_data_out      = main_vld_q ? main_q.rdata1  : '0;
    assign reg2_data_out      = main_vld_q ? main_q.rdata2  : '0;
    assign illegal_out        = main_vld_q ? main_q.illegal : 1'b0;

endmodule

// File: tb/tb_core_id_pipe.sv
// Self-checking bench for core_id_pipe: directed scenarios plus randomized
// traffic against a queue-based reference model of the decode stage.
module tb_core_id_pipe;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int OPC_W  = 4;
    localparam int BW     = 181;
    localparam logic [6:0] OPS [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                        7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush_in = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       inst_in = '0;
    logic [XLEN-1:0]   inst_addr_in = '0;
    logic [REG_AW-1:0] read_reg1_addr_out, read_reg2_addr_out;
    logic [XLEN-1:0]   read_reg1_data_in, read_reg2_data_in;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       inst_out;
    logic [XLEN-1:0]   inst_addr_out;
    logic [OPC_W-1:0]  opclass_out;
    logic [2:0]        func3_out;
    logic [6:0]        func7_out;
    logic [XLEN-1:0]   imm_out;
    logic              reg_we_out;
    logic [REG_AW-1:0] reg_write_addr_out;
    logic [XLEN-1:0]   reg1_data_out, reg2_data_out;
    logic              illegal_out;
`ifdef CORE_ID_HAZARD_EN
    logic              ex_load_valid_in = 1'b0;
    logic [REG_AW-1:0] ex_rd_in = '0;
    logic              hazard_stall_out;
`endif

    logic [31:0]     rf [32];
    logic [BW-1:0]   q [$];
    int              n_checks = 0;
    int              n_fail = 0;

    assign read_reg1_data_in = rf[read_reg1_addr_out];
    assign read_reg2_data_in = rf[read_reg2_addr_out];

    always #5 clk = ~clk;

    core_id_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .OPC_W(OPC_W)) dut (
        .clk(clk), .rst(rst), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst_in(inst_in), .inst_addr_in(inst_addr_in),
        .read_reg1_addr_out(read_reg1_addr_out), .read_reg2_addr_out(read_reg2_addr_out),
        .read_reg1_data_in(read_reg1_data_in), .read_reg2_data_in(read_reg2_data_in),
`ifdef CORE_ID_HAZARD_EN
        .ex_load_valid_in(ex_load_valid_in), .ex_rd_in(ex_rd_in),
        .hazard_stall_out(hazard_stall_out),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .inst_out(inst_out), .inst_addr_out(inst_addr_out),
        .opclass_out(opclass_out), .func3_out(func3_out), .func7_out(func7_out),
        .imm_out(imm_out), .reg_we_out(reg_we_out),
        .reg_write_addr_out(reg_write_addr_out),
        .reg1_data_out(reg1_data_out), .reg2_data_out(reg2_data_out),
        .illegal_out(illegal_out)
    );

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Class of an instruction per the RV32I rules; 0 means illegal.
    function automatic int ref_class(input logic [31:0] i);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        case (i[6:0])
            7'h37: return 1;
            7'h17: return 2;
            7'h6F: return 3;
            7'h67: return 4;
            7'h63: return 5;
            7'h03: return 6;
            7'h23: return 7;
            7'h13: return 8;
            7'h33: begin
                if (f7 != 7'h00 && f7 != 7'h20) return 0;
                if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) return 0;
                return 9;
            end
            7'h0F: return 10;
            7'h73: return 11;
            default: return 0;
        endcase
    endfunction

    function automatic logic [9:0] ref_raddr(input logic [31:0] i);
        int c;
        logic [4:0] a1, a2;
        c  = ref_class(i);
        a1 = (c inside {4, 5, 6, 7, 8, 9, 11}) ? i[19:15] : 5'd0;
        a2 = (c inside {5, 7, 9}) ? i[24:20] : 5'd0;
        return {a1, a2};
    endfunction

    function automatic logic [BW-1:0] ref_bundle(input logic [31:0] i, input logic [31:0] a);
        int          c;
        logic [31:0] imm, d1, d2;
        logic [9:0]  ra;
        logic        we;
        c = ref_class(i);
        case (c)
            1, 2:       imm = {i[31:12], 12'h000};
            3:          imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            5:          imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            7:          imm = 32'($signed({i[31:25], i[11:7]}));
            8:          imm = (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? {27'd0, i[24:20]}
                                                                     : 32'($signed(i[31:20]));
            4, 6, 10, 11: imm = 32'($signed(i[31:20]));
            default:    imm = 32'd0;
        endcase
        ra = ref_raddr(i);
        d1 = (ra[9:5] == 5'd0) ? 32'd0 : rf[ra[9:5]];
        d2 = (ra[4:0] == 5'd0) ? 32'd0 : rf[ra[4:0]];
        we = (c inside {1, 2, 3, 4, 6, 8, 9}) && (i[11:7] != 5'd0);
        return {i, a, 4'(c), i[14:12], i[31:25], imm, we, (we ? i[11:7] : 5'd0), d1, d2, (c == 0)};
    endfunction

    function automatic logic [BW-1:0] obs_bundle();
        return {inst_out, inst_addr_out, opclass_out, func3_out, func7_out, imm_out,
                reg_we_out, reg_write_addr_out, reg1_data_out, reg2_data_out, illegal_out};
    endfunction

    function automatic logic model_hazard();
`ifdef CORE_ID_HAZARD_EN
        logic [9:0] ra;
        if (q.size() == 0 || !ex_load_valid_in || ex_rd_in == '0) return 1'b0;
        ra = ref_raddr(q[0][180:149]);
        return (ra[9:5] == ex_rd_in) || (ra[4:0] == ex_rd_in);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_state();
        logic hz;
        hz = model_hazard();
        check("out_valid", out_valid, (q.size() > 0) && !hz);
        check("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0 && !hz) check("bundle", obs_bundle(), q[0]);
`ifdef CORE_ID_HAZARD_EN
        check("hazard_stall", hazard_stall_out, (q.size() > 0) && hz);
`endif
    endtask

    // One clock: drive inputs, advance the model as the edge will, then check.
    task automatic step(input logic v, input logic [31:0] inst, input logic ordy, input logic fl);
        logic [BW-1:0] exp_b;
        logic          hz, drn, acc;
        in_valid     = v;
        inst_in      = inst;
        inst_addr_in = $urandom;
        out_ready    = ordy;
        flush_in     = fl;
        #1;
        check("raddr", {read_reg1_addr_out, read_reg2_addr_out}, ref_raddr(inst));
        hz    = model_hazard();
        exp_b = ref_bundle(inst, inst_addr_in);
        if (fl) begin
            q.delete();
        end else begin
            drn = (q.size() > 0) && !hz && ordy;
            acc = v && (q.size() < 2);
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(exp_b);
        end
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        w = $urandom;
        w[6:0] = OPS[$urandom_range(0, 11)];
        if ($urandom_range(0, 9) == 0) w[6:0] = 7'($urandom);
        if (w[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: ;
            endcase
        end
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        if ($urandom_range(0, 7) == 0) w[19:15] = 5'd0;
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int idx;
        logic [31:0] stream [4];
        logic acc_now;

        for (int r = 0; r < 32; r++) rf[r] = $urandom;
        rf[0] = 32'hDEAD_BEEF;
        rf[2] = 32'd100;

        // Reset held together with flush and a valid request.
        rst = 1'b0; flush_in = 1'b1; in_valid = 1'b1; inst_in = 32'hFFB10093;
        @(posedge clk); @(posedge clk); @(negedge clk);
        q.delete();
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_bundle_zero", obs_bundle(), '0);
        rst = 1'b1;

        step(1'b1, 32'hFFB10093, 1'b1, 1'b0);
        check("addi_opclass", opclass_out, 4'd8);
        check("addi_imm", imm_out, 32'hFFFF_FFFB);
        check("addi_we", reg_we_out, 1'b1);
        check("addi_rd", reg_write_addr_out, 5'd1);
        check("addi_reg1", reg1_data_out, 32'd100);

        step(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
        check("beq_imm", imm_out, 32'hFFFF_FFFC);
        check("beq_we", reg_we_out, 1'b0);
        check("beq_opclass", opclass_out, 4'd5);

        step(1'b1, 32'h1234_567F, 1'b1, 1'b0);
        check("opc7f_illegal", illegal_out, 1'b1);
        check("opc7f_opclass", opclass_out, 4'd0);
        check("opc7f_we", reg_we_out, 1'b0);

        step(1'b1, 32'h0220_81B3, 1'b1, 1'b0);
        check("add_f7_illegal", illegal_out, 1'b1);
        check("add_f7_opclass", opclass_out, 4'd0);
        check("add_f7_we", reg_we_out, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Four-instruction stream with EX stalled for the first two cycles.
        stream = '{32'h0050_0293, 32'h0062_8333, 32'h0003_A403, 32'h0084_A023};
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 20) begin
            acc_now = in_ready;
            step(1'b1, stream[idx], (cyc >= 2), 1'b0);
            if (cyc == 1) check("stream_in_ready_low", in_ready, 1'b0);
            if (acc_now) idx++;
            cyc++;
        end
        check("stream_all_accepted", idx, 4);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill both entries, then flush.
        step(1'b1, gen_inst(), 1'b0, 1'b0);
        step(1'b1, gen_inst(), 1'b0, 1'b0);
        check("full_in_ready_low", in_ready, 1'b0);
        step(1'b1, gen_inst(), 1'b1, 1'b1);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);

`ifdef CORE_ID_HAZARD_EN
        ex_load_valid_in = 1'b1;
        ex_rd_in = 5'd5;
        step(1'b1, 32'h0072_8333, 1'b1, 1'b0);
        check("haz_stall", hazard_stall_out, 1'b1);
        check("haz_out_valid", out_valid, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("haz_held_stall", hazard_stall_out, 1'b1);
        ex_load_valid_in = 1'b0;
        #1;
        check("haz_release_valid", out_valid, 1'b1);
        check("haz_release_stall", hazard_stall_out, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
`endif

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, gen_inst(), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 31) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
